// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: pipeline-side request/response signals and memory-macro signals
// of mem_port_arbiter; the arbiter connects through the slave modport.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        fetch_stall;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_valid;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_valid, if_rdata, fetch_stall, d_valid, d_rdata, mem_en, mem_we, mem_addr, mem_wdata
    );
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_valid, if_rdata, fetch_stall, d_valid, d_rdata, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store with fixed-latency sequencing.
// Define MEM_ARB_RR_EN for round-robin arbitration instead of data priority with a starvation limit.
module mem_port_arbiter #(
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus_io
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] BUSY_IF = 2'd1;
    localparam logic [1:0] BUSY_D  = 2'd2;
    localparam logic [3:0] LAT_M1  = 4'(MEM_LATENCY - 1);
    logic [1:0]  state_q, state_d;
    logic [3:0]  lat_q, lat_d;
    logic        mem_en_q, mem_en_d, mem_we_q, mem_we_d, acc_we_q, acc_we_d;
    logic        if_valid_q, if_valid_d, d_valid_q, d_valid_d;
    logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic [31:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
    logic        if_elig, d_elig, grant_if, grant_d, done;
    // a requester completing this cycle still holds its req and must not be re-granted
    assign if_elig = bus_io.if_req & ~if_valid_q;
    assign d_elig  = bus_io.d_req & ~d_valid_q;
`ifdef MEM_ARB_RR_EN
    logic last_d_q;
    assign grant_if = state_q == IDLE && if_elig && (!d_elig || last_d_q);
    always_ff @(posedge clk or posedge rst)
        if (rst) last_d_q <= 1'b0;
        else if (grant_if || grant_d) last_d_q <= grant_d;
`else
    localparam logic [3:0] SLIM = 4'(STARVE_LIMIT);
    logic [3:0] starve_q;
    assign grant_if = state_q == IDLE && if_elig && (!d_elig || starve_q == SLIM);
    always_ff @(posedge clk or posedge rst)
        if (rst) starve_q <= 4'd0;
        else if (grant_if) starve_q <= 4'd0;
        else if (grant_d && bus_io.if_req && starve_q != SLIM) starve_q <= starve_q + 4'd1;
`endif
    assign grant_d = state_q == IDLE && d_elig && !grant_if;
    assign done    = state_q != IDLE && lat_q == 4'd0;
    always_comb begin
        state_d     = done ? IDLE : state_q;
        lat_d       = state_q != IDLE && lat_q != 4'd0 ? lat_q - 4'd1 : lat_q;
        mem_en_d    = grant_if || grant_d;
        mem_we_d    = grant_d && bus_io.d_we;
        acc_we_d    = acc_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_valid_d  = done && state_q == BUSY_IF;
        d_valid_d   = done && state_q == BUSY_D;
        if_rdata_d  = done && state_q == BUSY_IF ? bus_io.mem_rdata : if_rdata_q;
        d_rdata_d   = done && state_q == BUSY_D && !acc_we_q ? bus_io.mem_rdata : d_rdata_q;
        if (grant_if || grant_d) begin
            state_d     = grant_d ? BUSY_D : BUSY_IF;
            lat_d       = LAT_M1;
            acc_we_d    = grant_d && bus_io.d_we;
            mem_addr_d  = grant_d ? bus_io.d_addr : bus_io.if_addr;
            mem_wdata_d = grant_d ? bus_io.d_wdata : mem_wdata_q;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            lat_q       <= 4'd0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            acc_we_q    <= 1'b0;
            if_valid_q  <= 1'b0;
            d_valid_q   <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            if_rdata_q  <= 32'd0;
            d_rdata_q   <= 32'd0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            acc_we_q    <= acc_we_d;
            if_valid_q  <= if_valid_d;
            d_valid_q   <= d_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end
    assign bus_io.mem_en      = mem_en_q;
    assign bus_io.mem_we      = mem_we_q;
    assign bus_io.mem_addr    = mem_addr_q;
    assign bus_io.mem_wdata   = mem_wdata_q;
    assign bus_io.if_valid    = if_valid_q;
    assign bus_io.if_rdata    = if_rdata_q;
    assign bus_io.d_valid     = d_valid_q;
    assign bus_io.d_rdata     = d_rdata_q;
    assign bus_io.fetch_stall = bus_io.if_req & ~if_valid_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench; stimulus queues expected memory accesses and
// responses with their cycle numbers, a negedge monitor pops and compares them.
module tb_mem_port_arbiter;
    localparam int L = 2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int rd_c = -10;
    logic [31:0] rd_data = 32'd0;
    typedef struct {int c; logic [31:0] addr; logic we; logic chk_wd; logic [31:0] wd;} acc_t;
    typedef struct {int c; logic [31:0] data;} rsp_t;
    acc_t mem_q[$];
    rsp_t if_q[$];
    rsp_t d_q[$];

    mem_port_arbiter_if bus();
    mem_port_arbiter #(.MEM_LATENCY(L), .STARVE_LIMIT(4)) dut (.clk(clk), .rst(rst), .bus_io(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] model(input logic [31:0] a);
        return a == 32'h100 ? 32'hDEADBEEF : a == 32'h200 ? 32'hCAFE0200 : {16'hA5A5, a[15:0]};
    endfunction

    task automatic chk(input bit ok, input string name, input string got, input string want);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %s, want %s", name, got, want);
        end
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_mem(input int c, input logic [31:0] a, input logic we, input logic [31:0] wd);
        acc_t e;
        e.c = c; e.addr = a; e.we = we; e.chk_wd = we; e.wd = wd;
        mem_q.push_back(e);
    endtask

    task automatic push_rsp(input bit is_d, input int c, input logic [31:0] data);
        rsp_t e;
        e.c = c; e.data = data;
        if (is_d) d_q.push_back(e);
        else if_q.push_back(e);
    endtask

    // memory macro: data appears only in the cycle the arbiter is supposed to sample it
    always @(posedge clk) begin
        #1;
        bus.mem_rdata = (cyc == rd_c) ? rd_data : 32'hBAD0BAD0;
    end

    always @(negedge clk) begin
        acc_t a;
        rsp_t r;
        if (bus.mem_en) begin
            rd_c = cyc + L - 1;
            rd_data = model(bus.mem_addr);
            if (mem_q.size() == 0)
                chk(0, "mem_en_unexpected", $sformatf("cyc=%0d addr=%h", cyc, bus.mem_addr), "no access");
            else begin
                a = mem_q.pop_front();
                chk(cyc == a.c && bus.mem_addr == a.addr && bus.mem_we == a.we && (!a.chk_wd || bus.mem_wdata == a.wd),
                    "mem_access",
                    $sformatf("cyc=%0d addr=%h we=%b wd=%h", cyc, bus.mem_addr, bus.mem_we, bus.mem_wdata),
                    $sformatf("cyc=%0d addr=%h we=%b wd=%h", a.c, a.addr, a.we, a.wd));
            end
        end else if (bus.mem_we)
            chk(0, "mem_we_without_en", $sformatf("cyc=%0d mem_we=1", cyc), "mem_we=0");
        if (bus.if_valid) begin
            if (if_q.size() == 0)
                chk(0, "if_valid_unexpected", $sformatf("cyc=%0d", cyc), "no if_valid");
            else begin
                r = if_q.pop_front();
                chk(cyc == r.c && bus.if_rdata == r.data, "if_resp",
                    $sformatf("cyc=%0d rdata=%h", cyc, bus.if_rdata), $sformatf("cyc=%0d rdata=%h", r.c, r.data));
            end
        end
        if (bus.d_valid) begin
            if (d_q.size() == 0)
                chk(0, "d_valid_unexpected", $sformatf("cyc=%0d", cyc), "no d_valid");
            else begin
                r = d_q.pop_front();
                chk(cyc == r.c && bus.d_rdata == r.data, "d_resp",
                    $sformatf("cyc=%0d rdata=%h", cyc, bus.d_rdata), $sformatf("cyc=%0d rdata=%h", r.c, r.data));
            end
        end
    end

    task automatic chk_reset_outputs(input string name);
        logic [161:0] v;
        v = {bus.mem_en, bus.mem_we, bus.if_valid, bus.d_valid, bus.fetch_stall,
             bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.d_rdata};
        chk(v == '0, name, $sformatf("%h", v), "all zero");
    endtask

    initial begin
        int b;
        bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;
        bus.mem_rdata = 0;
        wait_to(2);
        @(negedge clk);
        chk_reset_outputs("reset_state");
        wait_to(3);
        rst = 0;
        // fetch only
        wait_to(5);
        b = cyc;
        bus.if_req = 1; bus.if_addr = 32'h100;
        push_mem(b + 1, 32'h100, 0, 0);
        push_rsp(0, b + 3, 32'hDEADBEEF);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk(bus.fetch_stall == (k < 3), $sformatf("fetch_stall_c%0d", k),
                $sformatf("%b", bus.fetch_stall), $sformatf("%b", k < 3));
            @(posedge clk);
            #1;
            if (k == 0) bus.if_addr = 32'hFFFF_FFF0;
        end
        bus.if_req = 0;
        // collision: data first, fetch waits for the next IDLE
        b = cyc + 2;
        wait_to(b);
        bus.if_req = 1; bus.if_addr = 32'h104;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h200;
        push_mem(b + 1, 32'h200, 0, 0);
        push_rsp(1, b + 3, 32'hCAFE0200);
        push_mem(b + 4, 32'h104, 0, 0);
        push_rsp(0, b + 6, 32'hA5A50104);
        wait_to(b + 4);
        bus.d_req = 0;
        wait_to(b + 7);
        bus.if_req = 0;
        // write: d_rdata keeps the previous load value
        b = cyc + 2;
        wait_to(b);
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h300; bus.d_wdata = 32'h1234;
        push_mem(b + 1, 32'h300, 1, 32'h1234);
        push_rsp(1, b + 3, 32'hCAFE0200);
        wait_to(b + 1);
        bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
        wait_to(b + 4);
        bus.d_req = 0; bus.d_we = 0;
        // starvation: four data wins with fetch pending, then fetch wins
        b = cyc + 2;
        for (int r = 0; r < 4; r++) begin
            wait_to(b + 4 * r);
            bus.if_req = 1; bus.if_addr = 32'h400 + 32'(4 * r);
            bus.d_req = 1; bus.d_addr = 32'h500 + 32'(4 * r);
            push_mem(b + 4 * r + 1, 32'h500 + 32'(4 * r), 0, 0);
            push_rsp(1, b + 4 * r + 3, 32'hA5A50500 + 32'(4 * r));
            wait_to(b + 4 * r + 1);
            bus.if_req = 0;
        end
        b = b + 16;
        wait_to(b);
        bus.if_req = 1; bus.if_addr = 32'h480; bus.d_addr = 32'h580;
        push_mem(b + 1, 32'h480, 0, 0);
        push_rsp(0, b + 3, 32'hA5A50480);
        push_mem(b + 4, 32'h580, 0, 0);
        push_rsp(1, b + 6, 32'hA5A50580);
        wait_to(b + 4);
        bus.if_req = 0;
        wait_to(b + 7);
        bus.if_req = 1; bus.if_addr = 32'h490; bus.d_addr = 32'h590;
        push_mem(b + 8, 32'h590, 0, 0);
        push_rsp(1, b + 10, 32'hA5A50590);
        push_mem(b + 11, 32'h490, 0, 0);
        push_rsp(0, b + 13, 32'hA5A50490);
        wait_to(b + 11);
        bus.d_req = 0;
        wait_to(b + 14);
        bus.if_req = 0;
        // reset in the cycle after mem_en abandons the fetch
        b = cyc + 2;
        wait_to(b);
        bus.if_req = 1; bus.if_addr = 32'h600;
        push_mem(b + 1, 32'h600, 0, 0);
        wait_to(b + 2);
        rst = 1;
        bus.if_req = 0;
        @(negedge clk);
        chk_reset_outputs("reset_mid_access");
        wait_to(b + 3);
        rst = 0;
        wait_to(b + 8);
        bus.if_req = 1; bus.if_addr = 32'h700;
        push_mem(b + 9, 32'h700, 0, 0);
        push_rsp(0, b + 11, 32'hA5A50700);
        wait_to(b + 12);
        bus.if_req = 0;
        wait_to(b + 16);
        chk(mem_q.size() == 0, "mem_q_drained", $sformatf("%0d left", mem_q.size()), "0 left");
        chk(if_q.size() == 0, "if_q_drained", $sformatf("%0d left", if_q.size()), "0 left");
        chk(d_q.size() == 0, "d_q_drained", $sformatf("%0d left", d_q.size()), "0 left");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
